// File: rtl/if_neuron_scheduler.sv
// Round-robin integrate-and-fire scheduler: one shared update datapath serves N_NEURONS virtual neurons.
// Optional membrane leak before integration is enabled by defining IF_SCHED_LEAK_EN.
module if_neuron_scheduler #(
   parameter int N_NEURONS  = 4,
   parameter int WIDTH      = 8,
   parameter int REFRAC     = 2,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic                         in_valid,
   input  logic [$clog2(N_NEURONS)-1:0] in_id,
   input  logic [WIDTH-1:0]             current_in,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             threshold,
   input  logic [$clog2(N_NEURONS)-1:0] mon_id,
   output logic [WIDTH-1:0]             state_mon,
   output logic                         spike,
   output logic [$clog2(N_NEURONS)-1:0] spike_id
);
   localparam int IDW = $clog2(N_NEURONS);
   localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   generate
      if (N_NEURONS < 2 || N_NEURONS > 16 || (N_NEURONS & (N_NEURONS - 1)) != 0) begin : g_bad_n
         $error("N_NEURONS must be a power of two in 2..16");
      end
      if (LEAK_SHIFT < 0 || REFRAC < 0) begin : g_bad_cfg
         $error("LEAK_SHIFT and REFRAC must be non-negative");
      end
   endgenerate

   typedef enum logic {FETCH = 1'b0, COMMIT = 1'b1} phase_t;

   phase_t                        phase, phase_nxt;
   logic [IDW-1:0]                slot, slot_nxt;

   logic [N_NEURONS-1:0][WIDTH-1:0] membrane;
   logic [N_NEURONS-1:0][WIDTH-1:0] pending;
   logic [N_NEURONS-1:0]            pend_v;
   logic [N_NEURONS-1:0][RW-1:0]    refrac;

   logic [WIDTH-1:0] f_mem;
   logic [WIDTH-1:0] f_pend;
   logic             f_pv;
   logic [RW-1:0]    f_ref;

   logic             fetch_en, commit_en, accept;
   logic [WIDTH-1:0] base, addend, sum;
   logic [WIDTH:0]   raw;
   logic             in_refrac, fire;

   assign fetch_en  = ena && (phase == FETCH);
   assign commit_en = ena && (phase == COMMIT);
   assign in_ready  = ena & ~pend_v[in_id];
   assign accept    = in_valid & in_ready;
   assign state_mon = membrane[mon_id];

`ifdef IF_SCHED_LEAK_EN
   // shift amount never exceeds the value, so the subtraction cannot go negative
   assign base = f_mem - (f_mem >> LEAK_SHIFT);
`else
   assign base = f_mem;
`endif

   assign addend    = f_pv ? f_pend : '0;
   assign raw       = {1'b0, base} + {1'b0, addend};
   assign sum       = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
   assign in_refrac = (f_ref != '0);
   assign fire      = !in_refrac && (sum >= threshold);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= FETCH;
         slot  <= '0;
      end else begin
         phase <= phase_nxt;
         slot  <= slot_nxt;
      end
   end

   always_comb begin
      phase_nxt = phase;
      slot_nxt  = slot;
      if (ena) begin
         case (phase)
            FETCH:   phase_nxt = COMMIT;
            COMMIT: begin
               phase_nxt = FETCH;
               slot_nxt  = slot + 1'b1;
            end
            default: phase_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         membrane <= '0;
         pending  <= '0;
         pend_v   <= '0;
         refrac   <= '0;
         f_mem    <= '0;
         f_pend   <= '0;
         f_pv     <= 1'b0;
         f_ref    <= '0;
         spike    <= 1'b0;
         spike_id <= '0;
      end else begin
         spike <= 1'b0;
         if (fetch_en) begin
            f_mem  <= membrane[slot];
            f_pend <= pending[slot];
            f_pv   <= pend_v[slot];
            f_ref  <= refrac[slot];
         end
         if (commit_en) begin
            if (in_refrac) begin
               refrac[slot]   <= f_ref - RW'(1);
               membrane[slot] <= '0;
            end else if (fire) begin
               membrane[slot] <= '0;
               refrac[slot]   <= RW'(REFRAC);
               spike          <= 1'b1;
               spike_id       <= slot;
            end else begin
               membrane[slot] <= sum;
            end
            // only the current captured at FETCH is consumed; a later arrival waits a round
            if (f_pv)
               pend_v[slot] <= 1'b0;
         end
         if (accept) begin
            pending[in_id] <= current_in;
            pend_v[in_id]  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_if_neuron_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a per-neuron behavioural model.
module tb_if_neuron_scheduler;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int RF = 2;
   localparam int LS = 3;

   logic         clk = 1'b0;
   logic         rst, ena, in_valid;
   logic [1:0]   in_id, mon_id;
   logic [W-1:0] current_in, threshold;
   logic         in_ready, spike;
   logic [W-1:0] state_mon;
   logic [1:0]   spike_id;

   if_neuron_scheduler #(.N_NEURONS(N), .WIDTH(W), .REFRAC(RF), .LEAK_SHIFT(LS)) dut (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_id(in_id),
      .current_in(current_in), .in_ready(in_ready), .threshold(threshold),
      .mon_id(mon_id), .state_mon(state_mon), .spike(spike), .spike_id(spike_id)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model: per-neuron quantities and position in the round
   int m_mem[N], m_pend[N], m_pv[N], m_rf[N];
   int m_slot, m_ph, m_fpv;
   bit exp_spike;
   int exp_sid;
   int spikes_seen, last_sid;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mem[i] = 0; m_pend[i] = 0; m_pv[i] = 0; m_rf[i] = 0;
      end
      m_slot = 0; m_ph = 0; m_fpv = 0; exp_spike = 0; exp_sid = 0;
   endtask

   task automatic model_edge();
      bit acc;
      int b, s;
      exp_spike = 0;
      if (!ena) return;
      acc = in_valid && (m_pv[in_id] == 0);
      if (m_ph == 0) begin
         m_fpv = m_pv[m_slot];
         m_ph  = 1;
      end else begin
         if (m_rf[m_slot] > 0) begin
            m_rf[m_slot]--;
            m_mem[m_slot] = 0;
         end else begin
            b = m_mem[m_slot];
`ifdef IF_SCHED_LEAK_EN
            b = b - (b >> LS);
`endif
            s = b + (m_fpv ? m_pend[m_slot] : 0);
            if (s > 255) s = 255;
            if (s >= threshold) begin
               exp_spike = 1; exp_sid = m_slot;
               m_mem[m_slot] = 0; m_rf[m_slot] = RF;
            end else begin
               m_mem[m_slot] = s;
            end
         end
         if (m_fpv) m_pv[m_slot] = 0;
         m_slot = (m_slot + 1) % N;
         m_ph   = 0;
      end
      if (acc) begin
         m_pend[in_id] = current_in;
         m_pv[in_id]   = 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("in_ready", in_ready, ena && (m_pv[in_id] == 0));
      @(posedge clk);
      model_edge();
      #1;
      chk("spike", spike, exp_spike);
      if (exp_spike) begin
         chk("spike_id", spike_id, exp_sid);
         spikes_seen++;
         last_sid = exp_sid;
      end
      chk("state_mon", state_mon, m_mem[mon_id]);
   endtask

   task automatic peek(input int id, input int exp, input string tag);
      mon_id = id[1:0];
      #1;
      chk(tag, state_mon, exp);
   endtask

   task automatic sync_fetch(input int k);
      bit ok = 0;
      in_valid = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_ph == 0 && m_slot == k) begin ok = 1; break; end
         step();
      end
      chk("sync_timeout", ok, 1);
   endtask

   task automatic send(input int id, input int cur);
      bit ok = 0;
      in_valid = 1; in_id = id[1:0]; current_in = cur[W-1:0];
      for (int i = 0; i < 64; i++) begin
         if (ena && m_pv[id] == 0) begin ok = 1; step(); break; end
         step();
      end
      in_valid = 0;
      chk("send_timeout", ok, 1);
   endtask

   // deliver one current so that exactly the next commit of neuron k consumes it
   task automatic feed(input int k, input int cur);
      sync_fetch((k + 1) % N);
      send(k, cur);
      sync_fetch((k + 1) % N);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, stalls;
      rst = 1; ena = 1; in_valid = 0; in_id = 0; current_in = 0;
      threshold = 8'hE6; mon_id = 0; spikes_seen = 0; last_sid = 0;
      #5;
      chk("rst_spike", spike, 0);
      chk("rst_spike_id", spike_id, 0);
      for (int i = 0; i < N; i++) peek(i, 0, "rst_state");
      @(posedge clk); #1 rst = 0;
      model_reset();

`ifndef IF_SCHED_LEAK_EN
      s0 = spikes_seen;
      feed(0, 100); peek(0, 100, "n0_first");
      feed(0, 100); peek(0, 200, "n0_second");
      feed(0, 50);  peek(0, 0, "n0_after_spike");
      chk("n0_spikes", spikes_seen - s0, 1);
      chk("n0_spike_id", last_sid, 0);

      s0 = spikes_seen;
      feed(2, 200); peek(2, 200, "n2_first");
      feed(2, 200); peek(2, 0, "n2_saturated");
      chk("n2_spikes", spikes_seen - s0, 1);
      chk("n2_spike_id", last_sid, 2);

      feed(1, 250); peek(1, 0, "n1_fire");
      chk("n1_spike_id", last_sid, 1);
      feed(1, 150); peek(1, 0, "n1_refrac1");
      feed(1, 150); peek(1, 0, "n1_refrac2");
      feed(1, 150); peek(1, 150, "n1_resumed");

      sync_fetch(0);
      in_valid = 1; in_id = 3; current_in = 40;
      step();
      current_in = 50; stalls = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_pv[3] == 0) begin step(); break; end
         stalls++;
         step();
      end
      in_valid = 0;
      chk("n3_stall", stalls, 7);
      sync_fetch(0);
      peek(3, 90, "n3_both");
`else
      feed(0, 200); peek(0, 200, "leak_n0_200");
      feed(0, 0);   peek(0, 175, "leak_n0_175");
      s0 = spikes_seen;
      feed(2, 200); peek(2, 200, "leak_n2_200");
      feed(2, 60);  peek(2, 0, "leak_n2_spike");
      chk("leak_spikes", spikes_seen - s0, 1);
      chk("leak_spike_id", last_sid, 2);
      feed(3, 90);
`endif

      // pause in the middle of a slot
      sync_fetch(2);
      step();
      s0 = spikes_seen;
      ena = 0; in_valid = 1; in_id = 2; current_in = 77;
      repeat (10) step();
      chk("pause_spikes", spikes_seen - s0, 0);
      for (int i = 0; i < N; i++) peek(i, m_mem[i], "pause_state");
      ena = 1; in_valid = 0;
      feed(3, 20);
      peek(3, m_mem[3], "resume_n3");

      // asynchronous reset landing during a COMMIT
      sync_fetch(1);
      step();
      rst = 1;
      #1;
      chk("rst_mid_spike", spike, 0);
      chk("rst_mid_spike_id", spike_id, 0);
      for (int i = 0; i < N; i++) peek(i, 0, "rst_mid_state");
      model_reset();
      @(posedge clk); #1 rst = 0;

      for (int n = 0; n < 800; n++) begin
         ena        = ($urandom % 10) != 0;
         in_valid   = $urandom % 2;
         in_id      = 2'($urandom % N);
         current_in = 8'($urandom);
         mon_id     = 2'($urandom % N);
         if ($urandom % 50 == 0) threshold = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
